// File: rtl/touch_key_pulse_gen.sv
// ---------------------------------------------------------------------------
// touch_key_pulse_gen
//
// Purpose:
//   Produces a burst of simulated touch-key presses. Each press drives the
//   touch line high for PRESS_CYC cycles and then low for GAP_CYC cycles.
//   Every press therefore produces exactly one falling edge, which is the
//   event that downstream toggle logic reacts to. A start/busy/done
//   handshake frames the burst. Abort or reset drops the line low at once.
//
// Ports:
//   sys_clk    in   1      system clock, rising edge
//   sys_rst    in   1      synchronous reset, active-high
//   start      in   1      request a burst (only looked at while idle)
//   press_num  in   CNT_W  number of presses, captured when start is taken
//   abort      in   1      cancel the burst in progress
//   touch_key  out  1      generated touch line, high = touched (registered)
//   busy       out  1      high while presses/gaps are being generated
//   done       out  1      one-cycle pulse when a burst ends normally
//   press_cnt  out  CNT_W  presses completed in the current/last burst
// ---------------------------------------------------------------------------
module touch_key_pulse_gen #(
    parameter int PRESS_CYC = 5_000_000,
    parameter int GAP_CYC   = 5_000_000,
    parameter int CNT_W     = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [CNT_W-1:0] press_num,
    input  logic             abort,
    output logic             touch_key,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] press_cnt
);

    // One timer serves both phases, so it is sized for the longer of the two.
    localparam int TMAX = (PRESS_CYC > GAP_CYC) ? PRESS_CYC : GAP_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0]    PRESS_LOAD = TW'(PRESS_CYC - 1);
    localparam logic [TW-1:0]    GAP_LOAD   = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0]    TIMER_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP,
        FIN
    } state_t;

    state_t           state;
    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] press_target;

    // Single sequential block: the next state and the registered outputs are
    // decided together, so touch_key/busy/done always line up with the state
    // they describe and never glitch. done is a pulse, so it defaults low
    // and is only raised on the transition into FIN.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            timer        <= TIMER_ZERO;
            press_target <= '0;
            press_cnt    <= '0;
            touch_key    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        press_cnt <= '0;
                        if (press_num != '0) begin
                            press_target <= press_num;
                            timer        <= PRESS_LOAD;
                            touch_key    <= 1'b1;
                            busy         <= 1'b1;
                            state        <= PRESS;
                        end else begin
                            // Empty burst: report completion without ever
                            // touching the line.
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end

                PRESS: begin
                    if (abort) begin
                        // A cut-short press still left a falling edge on the
                        // line, so it is counted.
                        press_cnt <= press_cnt + CNT_ONE;
                        timer     <= TIMER_ZERO;
                        touch_key <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (timer == TIMER_ZERO) begin
                        press_cnt <= press_cnt + CNT_ONE;
                        timer     <= GAP_LOAD;
                        touch_key <= 1'b0;
                        state     <= GAP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                GAP: begin
                    if (abort) begin
                        timer <= TIMER_ZERO;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (timer == TIMER_ZERO) begin
                        if (press_cnt < press_target) begin
                            timer     <= PRESS_LOAD;
                            touch_key <= 1'b1;
                            state     <= PRESS;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                FIN: begin
                    // Start and abort are deliberately ignored here; the
                    // earliest restart is taken in the following IDLE cycle.
                    state <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    touch_key <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_touch_key_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_touch_key_pulse_gen
//
// Purpose:
//   Self-checking bench for touch_key_pulse_gen with PRESS_CYC=4, GAP_CYC=3.
//   A reference model describes a burst purely by how many cycles have passed
//   since start was accepted; a monitor compares every DUT output against it
//   on each falling clock edge. Directed scenarios add hand-computed literal
//   checks at the key cycles.
// ---------------------------------------------------------------------------
module tb_touch_key_pulse_gen;

    localparam int P   = 4;
    localparam int G   = 3;
    localparam int PER = P + G;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] press_num = 8'd0;
    logic       abort = 1'b0;
    logic       touch_key;
    logic       busy;
    logic       done;
    logic [7:0] press_cnt;

    int errors = 0;
    int checks = 0;
    int cur = 0;
    bit chk_en = 1'b0;

    touch_key_pulse_gen #(
        .PRESS_CYC(P),
        .GAP_CYC  (G),
        .CNT_W    (8)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .start    (start),
        .press_num(press_num),
        .abort    (abort),
        .touch_key(touch_key),
        .busy     (busy),
        .done     (done),
        .press_cnt(press_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: m_k is the 1-based cycle number inside the burst.
    // m_zfin marks the done cycle of an empty (press_num=0) burst.
    // m_hold is the press count shown while idle.
    bit m_active = 1'b0;
    bit m_zfin = 1'b0;
    int m_k = 0;
    int m_n = 0;
    int m_hold = 0;

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            m_active <= 1'b0;
            m_zfin   <= 1'b0;
            m_k      <= 0;
            m_n      <= 0;
            m_hold   <= 0;
        end else if (m_active) begin
            if (m_k <= m_n * PER && abort) begin
                m_active <= 1'b0;
                m_hold   <= (m_k - 1) / PER + 1;
            end else if (m_k == m_n * PER + 1) begin
                m_active <= 1'b0;
                m_hold   <= m_n;
            end else begin
                m_k <= m_k + 1;
            end
        end else if (m_zfin) begin
            m_zfin <= 1'b0;
        end else if (start) begin
            m_hold <= 0;
            if (press_num != 8'd0) begin
                m_active <= 1'b1;
                m_k      <= 1;
                m_n      <= int'(press_num);
            end else begin
                m_zfin <= 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge sys_clk) begin
        if (chk_en) begin
            int et;
            int eb;
            int ed;
            int ec;
            int off;
            int idx;
            et = 0;
            eb = 0;
            ed = 0;
            ec = m_hold;
            if (m_active && m_k <= m_n * PER) begin
                off = (m_k - 1) % PER;
                idx = (m_k - 1) / PER;
                et  = (off < P) ? 1 : 0;
                eb  = 1;
                ec  = idx + ((off >= P) ? 1 : 0);
            end else if (m_active) begin
                ed = 1;
                ec = m_n;
            end else if (m_zfin) begin
                ed = 1;
                ec = 0;
            end
            checkOutput("model_touch_key", int'(touch_key), et);
            checkOutput("model_busy", int'(busy), eb);
            checkOutput("model_done", int'(done), ed);
            checkOutput("model_press_cnt", int'(press_cnt), ec);
        end
    end

    task automatic applyStimulus(input logic s, input logic [7:0] n, input logic a, input logic r);
        start     = s;
        press_num = n;
        abort     = a;
        sys_rst   = r;
    endtask

    task automatic stepTo(input int c);
        while (cur < c) begin
            @(posedge sys_clk);
            #1;
            cur++;
        end
    endtask

    initial begin
        int rises;
        logic prev_tk;

        // Reset held for several edges with noise on start/abort.
        @(posedge sys_clk);
        #1;
        chk_en = 1'b1;
        cur = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)), 1'b1);
            stepTo(i + 1);
            checkOutput("rst_touch_key", int'(touch_key), 0);
            checkOutput("rst_busy", int'(busy), 0);
            checkOutput("rst_done", int'(done), 0);
            checkOutput("rst_press_cnt", int'(press_cnt), 0);
        end
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
        stepTo(6);

        // Two-press burst.
        $display("[TB] two-press burst");
        applyStimulus(1'b1, 8'd2, 1'b0, 1'b0);
        cur = 0;
        stepTo(1);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
        for (int c = 1; c <= 15; c++) begin
            stepTo(c);
            checkOutput("b2_touch_key", int'(touch_key),
                        ((c <= 4) || (c >= 8 && c <= 11)) ? 1 : 0);
            checkOutput("b2_busy", int'(busy), (c <= 14) ? 1 : 0);
            checkOutput("b2_done", int'(done), (c == 15) ? 1 : 0);
        end
        checkOutput("b2_press_cnt", int'(press_cnt), 2);
        stepTo(18);

        // Empty burst.
        $display("[TB] empty burst");
        applyStimulus(1'b1, 8'd0, 1'b0, 1'b0);
        cur = 0;
        stepTo(1);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
        checkOutput("b0_done_c1", int'(done), 1);
        checkOutput("b0_busy_c1", int'(busy), 0);
        checkOutput("b0_touch_c1", int'(touch_key), 0);
        stepTo(2);
        checkOutput("b0_done_c2", int'(done), 0);
        stepTo(4);

        // Three presses with an ignored start in the middle.
        $display("[TB] three-press burst with restart attempt");
        applyStimulus(1'b1, 8'd3, 1'b0, 1'b0);
        cur = 0;
        stepTo(1);
        applyStimulus(1'b0, 8'd3, 1'b0, 1'b0);
        rises = 1;
        prev_tk = touch_key;
        for (int c = 2; c <= 23; c++) begin
            if (c == 6) applyStimulus(1'b1, 8'd7, 1'b0, 1'b0);
            if (c == 7) applyStimulus(1'b0, 8'd7, 1'b0, 1'b0);
            stepTo(c);
            if (touch_key && !prev_tk) rises++;
            prev_tk = touch_key;
            if (c == 21) checkOutput("b3_done_c21", int'(done), 0);
            if (c == 22) checkOutput("b3_done_c22", int'(done), 1);
        end
        checkOutput("b3_pulses", rises, 3);
        checkOutput("b3_press_cnt", int'(press_cnt), 3);
        stepTo(26);

        // Abort during the first press.
        $display("[TB] abort in press");
        applyStimulus(1'b1, 8'd3, 1'b0, 1'b0);
        cur = 0;
        stepTo(1);
        applyStimulus(1'b0, 8'd3, 1'b0, 1'b0);
        stepTo(2);
        applyStimulus(1'b0, 8'd3, 1'b1, 1'b0);
        stepTo(3);
        applyStimulus(1'b0, 8'd3, 1'b0, 1'b0);
        checkOutput("abort_touch_key", int'(touch_key), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_press_cnt", int'(press_cnt), 1);
        stepTo(25);
        checkOutput("abort_press_cnt_late", int'(press_cnt), 1);

        // Reset during the gap.
        $display("[TB] reset in gap");
        applyStimulus(1'b1, 8'd2, 1'b0, 1'b0);
        cur = 0;
        stepTo(1);
        applyStimulus(1'b0, 8'd2, 1'b0, 1'b0);
        stepTo(6);
        checkOutput("gap_press_cnt_before", int'(press_cnt), 1);
        applyStimulus(1'b0, 8'd2, 1'b0, 1'b1);
        stepTo(7);
        applyStimulus(1'b0, 8'd2, 1'b0, 1'b0);
        checkOutput("gaprst_press_cnt", int'(press_cnt), 0);
        checkOutput("gaprst_busy", int'(busy), 0);
        stepTo(20);

        // Start held high: back-to-back single-press bursts.
        $display("[TB] start held high");
        applyStimulus(1'b1, 8'd1, 1'b0, 1'b0);
        cur = 0;
        stepTo(8);
        checkOutput("held_done_c8", int'(done), 1);
        stepTo(9);
        checkOutput("held_touch_c9", int'(touch_key), 0);
        checkOutput("held_busy_c9", int'(busy), 0);
        stepTo(10);
        checkOutput("held_touch_c10", int'(touch_key), 1);
        checkOutput("held_busy_c10", int'(busy), 1);
        applyStimulus(1'b0, 8'd1, 1'b0, 1'b0);
        stepTo(17);
        checkOutput("held_done_c17", int'(done), 1);
        stepTo(22);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
